// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that wraps one-byte producer payloads into 4-byte frames
// (sync, channel ID, payload, XOR checksum) and feeds them to the uart_top TX FIFO.
module uart_frame_arbiter #(
    parameter int unsigned     DBITS     = 8,
    parameter int unsigned     NREQ      = 4,
    parameter logic [DBITS-1:0] SYNC_BYTE = DBITS'(8'hA5)
) (
    input  logic                    clk_100MHz,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*DBITS-1:0]   req_data,
    input  logic                    tx_full,
    output logic [NREQ-1:0]         ack,
    output logic                    write_uart,
    output logic [DBITS-1:0]        write_data,
    output logic                    busy,
    output logic [15:0]             frame_cnt
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_ID,
        ST_DATA,
        ST_SUM
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IW-1:0]     grant;
    logic [IW-1:0]     last_grant;
    logic [IW-1:0]     pick;
    logic [IW-1:0]     cand;
    logic              pick_valid;
    logic [DBITS-1:0]  payload;
    logic [DBITS-1:0]  id_byte;
    logic [DBITS-1:0]  sum_byte;
    logic              advance;

    assign id_byte  = DBITS'(grant);
    assign sum_byte = SYNC_BYTE ^ id_byte ^ payload;

    // A byte leaves the block only when an emit state meets a non-full FIFO.
    assign advance  = (state != ST_IDLE) && !tx_full;

    // First requester at or after last_grant+1, wrapping modulo NREQ.
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = IW'((32'(last_grant) + k) % NREQ);
            if (!pick_valid && req[cand]) begin
                pick_valid = 1'b1;
                pick       = cand;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (pick_valid) state_next = ST_SYNC;
            ST_SYNC: if (advance)    state_next = ST_ID;
            ST_ID:   if (advance)    state_next = ST_DATA;
            ST_DATA: if (advance)    state_next = ST_SUM;
            ST_SUM:  if (advance)    state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        write_uart = advance;
        write_data = '0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_SYNC: write_data = SYNC_BYTE;
            ST_ID:   write_data = id_byte;
            ST_DATA: write_data = payload;
            ST_SUM:  write_data = sum_byte;
            default: write_data = '0;
        endcase
    end

    // Grant capture, one-cycle ack pulse and completed-frame counter.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            grant      <= '0;
            last_grant <= IW'(NREQ - 1);
            payload    <= '0;
            ack        <= '0;
            frame_cnt  <= '0;
        end else begin
            ack <= '0;
            if (state == ST_IDLE && pick_valid) begin
                grant      <= pick;
                last_grant <= pick;
                payload    <= req_data[32'(pick) * DBITS +: DBITS];
                ack        <= NREQ'(1) << pick;
            end
            if (state == ST_SUM && advance) begin
                frame_cnt <= frame_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: a frame-level reference model is
// compared against the DUT every cycle, plus literal expectations per scenario.
module tb_uart_frame_arbiter;

    localparam int unsigned DBITS = 8;
    localparam int unsigned NREQ  = 4;
    localparam logic [7:0]  SYNC  = 8'hA5;

    logic              clk_100MHz = 1'b0;
    logic              reset      = 1'b1;
    logic [NREQ-1:0]   req        = '0;
    logic [NREQ*DBITS-1:0] req_data = '0;
    logic              tx_full    = 1'b0;
    logic [NREQ-1:0]   ack;
    logic              write_uart;
    logic [DBITS-1:0]  write_data;
    logic              busy;
    logic [15:0]       frame_cnt;

    always #5 clk_100MHz = ~clk_100MHz;

    uart_frame_arbiter #(.DBITS(DBITS), .NREQ(NREQ), .SYNC_BYTE(SYNC)) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .req        (req),
        .req_data   (req_data),
        .tx_full    (tx_full),
        .ack        (ack),
        .write_uart (write_uart),
        .write_data (write_data),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bytes still owed for the current frame, and its contents.
    bit          m_valid = 1'b0;
    int unsigned m_rem   = 0;
    int unsigned m_last  = NREQ - 1;
    logic [7:0]  m_frame [4];
    logic [3:0]  m_ack   = '0;
    logic [15:0] m_cnt   = '0;

    logic [7:0]  got [$];
    logic [3:0]  ack_seen = '0;
    int          stall_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout at %0t", name, $time);
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        logic [7:0] exp_wd;
        bit         found;
        int unsigned g;
        @(negedge clk_100MHz);
        if (m_valid) begin
            exp_wd = (m_rem > 0) ? m_frame[4 - m_rem] : 8'h00;
            chk("busy",       32'(busy),       32'(m_rem > 0));
            chk("write_uart", 32'(write_uart), 32'((m_rem > 0) && !tx_full));
            chk("write_data", 32'(write_data), 32'(exp_wd));
            chk("ack",        32'(ack),        32'(m_ack));
            chk("frame_cnt",  32'(frame_cnt),  32'(m_cnt));
        end
        if (write_uart === 1'b1) got.push_back(write_data);
        if (busy === 1'b1 && write_uart === 1'b0) stall_cnt++;
        ack_seen = ack_seen | ack;
        if (reset) begin
            m_valid = 1'b1;
            m_rem   = 0;
            m_last  = NREQ - 1;
            m_ack   = '0;
            m_cnt   = '0;
        end else if (m_rem == 0) begin
            m_ack = '0;
            found = 1'b0;
            for (int k = 1; k <= int'(NREQ); k++) begin
                g = (m_last + k) % NREQ;
                if (!found && req[g]) begin
                    found      = 1'b1;
                    m_last     = g;
                    m_frame[0] = SYNC;
                    m_frame[1] = 8'(g);
                    m_frame[2] = req_data[g*DBITS +: DBITS];
                    m_frame[3] = SYNC ^ m_frame[1] ^ m_frame[2];
                    m_rem      = 4;
                    m_ack      = 4'b0001 << g;
                end
            end
        end else begin
            m_ack = '0;
            if (!tx_full) begin
                m_rem--;
                if (m_rem == 0) m_cnt++;
            end
        end
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req     = '0;
        tx_full = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (busy !== 1'b0 && n < budget);
        if (n >= budget) timeout(name);
    endtask

    task automatic chk_frame(input string name, input int base, input logic [7:0] id, input logic [7:0] pl);
        chk({name, "_sync"}, 32'(got[base]),     32'(SYNC));
        chk({name, "_id"},   32'(got[base + 1]), 32'(id));
        chk({name, "_data"}, 32'(got[base + 2]), 32'(pl));
        chk({name, "_sum"},  32'(got[base + 3]), 32'(SYNC ^ id ^ pl));
    endtask

    initial begin
        int          n;
        int          acks;
        logic [15:0] prev;
        logic [15:0] changes [$];
        logic [1:0]  order [6];

        // Single request on channel 2
        do_reset();
        chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        req_data[2*8 +: 8] = 8'h3C;
        req      = 4'b0100;
        got.delete();
        ack_seen = '0;
        step();
        req = '0;
        run_until_idle("single", 20);
        chk("single_len", 32'(got.size()), 32'd4);
        chk("single_b0",  32'(got[0]), 32'hA5);
        chk("single_b1",  32'(got[1]), 32'h02);
        chk("single_b2",  32'(got[2]), 32'h3C);
        chk("single_b3",  32'(got[3]), 32'h9B);
        chk("single_ack", 32'(ack_seen), 32'b0100);
        chk("single_cnt", 32'(frame_cnt), 32'd1);
        chk("single_busy", 32'(busy), 32'd0);

        // Four simultaneous requests, each dropped on its ack
        do_reset();
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};
        req      = 4'b1111;
        got.delete();
        ack_seen = '0;
        n        = 0;
        acks     = 0;
        do begin
            step();
            n++;
            if (ack != '0) acks++;
            req = req & ~ack;
        end while (frame_cnt !== 16'd4 && n < 60);
        if (n >= 60) timeout("four");
        chk("four_cycles", 32'(n), 32'd20);
        chk("four_len",    32'(got.size()), 32'd16);
        for (int i = 0; i < 4; i++) chk_frame("four", i * 4, 8'(i), 8'h10 + 8'(i));
        chk("four_ack",    32'(ack_seen), 32'b1111);
        chk("four_pulses", 32'(acks), 32'd4);

        // Fairness between channels 0 and 3 held continuously
        req_data = {8'h23, 8'h22, 8'h21, 8'h20};
        req      = 4'b1001;
        got.delete();
        ack_seen = '0;
        acks     = 0;
        n        = 0;
        while (acks < 6 && n < 80) begin
            step();
            n++;
            if (ack != '0) acks++;
        end
        if (acks < 6) timeout("fair");
        req = '0;
        run_until_idle("fair_drain", 20);
        order = '{2'd0, 2'd3, 2'd0, 2'd3, 2'd0, 2'd3};
        chk("fair_len", 32'(got.size()), 32'd24);
        for (int i = 0; i < 6; i++) chk("fair_order", 32'(got[i * 4 + 1]), 32'(order[i]));
        chk("fair_ack", 32'(ack_seen), 32'b1001);

        // Backpressure for 10 cycles starting in DATA
        req_data[2*8 +: 8] = 8'h3C;
        req       = 4'b0100;
        got.delete();
        stall_cnt = 0;
        step();
        req = '0;
        step();
        step();
        tx_full = 1'b1;
        repeat (10) step();
        tx_full = 1'b0;
        run_until_idle("bp", 20);
        chk("bp_len",   32'(got.size()), 32'd4);
        chk_frame("bp", 0, 8'h02, 8'h3C);
        chk("bp_stall", 32'(stall_cnt), 32'd10);

        // Reset right after SYNC is written
        req_data[2*8 +: 8] = 8'h55;
        req = 4'b0100;
        step();
        req = '0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_write", 32'(write_uart), 32'd0);
        chk("mid_rst_cnt",   32'(frame_cnt),  32'd0);
        chk("mid_rst_ack",   32'(ack),        32'd0);
        got.delete();
        req_data[0*8 +: 8] = 8'h44;
        req_data[1*8 +: 8] = 8'h7E;
        req = 4'b0011;
        n   = 0;
        do begin
            step();
            n++;
            req = req & ~ack;
        end while (frame_cnt !== 16'd2 && n < 40);
        if (n >= 40) timeout("mid_rst");
        chk("mid_len", 32'(got.size()), 32'd8);
        chk_frame("mid_ch0", 0, 8'h00, 8'h44);
        chk("mid_ch1_sum", 32'(got[7]), 32'hDA);
        chk_frame("mid_ch1", 4, 8'h01, 8'h7E);

        // Counter wrap, starting the counter just short of 0xFFFF
        do_reset();
        force dut.frame_cnt = 16'hFFFD;
        m_cnt = 16'hFFFD;
        #1;
        release dut.frame_cnt;
        req_data[0*8 +: 8] = 8'h01;
        req  = 4'b0001;
        prev = 16'hFFFD;
        changes.delete();
        n = 0;
        while (changes.size() < 3 && n < 40) begin
            step();
            n++;
            if (frame_cnt !== prev) begin
                changes.push_back(frame_cnt);
                prev = frame_cnt;
            end
        end
        if (changes.size() < 3) timeout("wrap");
        req = '0;
        run_until_idle("wrap_drain", 20);
        chk("wrap_0", 32'(changes[0]), 32'hFFFE);
        chk("wrap_1", 32'(changes[1]), 32'hFFFF);
        chk("wrap_2", 32'(changes[2]), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_arbiter.md
# uart_frame_arbiter

Shares one `uart_top` transmitter among several on-chip producers, such as the audio level meter and the MOSFET PWM status logic. Each producer presents a one-byte payload under a request/acknowledge handshake. The block grants producers round-robin and wraps each payload in a 4-byte frame: sync, channel ID, payload, checksum. It pushes frame bytes into the `uart_top` TX FIFO through `write_uart`/`write_data` and honours the FIFO-full backpressure.

## Interface
- `DBITS`, 8, byte width; matches `uart_top` `DBITS`.
- `NREQ`, 4, number of requesters; legal range 2..16.
- `SYNC_BYTE`, 8'hA5, first byte of every frame.

- `clk_100MHz` in 1: system clock; every register in the block runs on its rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in NREQ: per-channel request, level; held until the matching `ack`.
- `req_data` in NREQ*DBITS: packed payloads; channel i at [i*DBITS +: DBITS]; stable while `req[i]` is high.
- `tx_full` in 1: `uart_top` TX FIFO full flag.
- `ack` out NREQ: one-cycle pulse; the channel's payload has been captured.
- `write_uart` out 1: FIFO write strobe to `uart_top`.
- `write_data` out DBITS: byte to write; valid when `write_uart` is high.
- `busy` out 1: high while a frame is in progress (state != IDLE).
- `frame_cnt` out 16: completed frames; wraps 0xFFFF -> 0x0000.

## Operation
- States:
  - IDLE: arbitrate.
  - SYNC: emit `SYNC_BYTE`.
  - ID: emit the channel ID.
  - DATA: emit the payload.
  - SUM: emit the checksum.
- IDLE:
  - No `req` bit set: stay in IDLE.
  - Otherwise grant the first set `req` bit, searching from (`last_grant`+1) mod NREQ upward with wrap.
  - On grant: latch the index into `grant` and `last_grant`, latch that channel's `req_data` into `payload`, go to SYNC.
- `ack[grant]` is registered: set on the edge leaving IDLE, cleared on the next edge. It is exactly one cycle wide and coincides with the first SYNC cycle. All other `ack` bits stay 0.
- Emit states (SYNC, ID, DATA, SUM):
  - `write_uart` = emit state AND !`tx_full`. It is combinational from registered state and `tx_full`.
  - The state advances only on a cycle with `write_uart`=1; otherwise it holds with `write_data` unchanged.
  - SYNC -> ID -> DATA -> SUM -> IDLE.
  - Leaving SUM increments `frame_cnt` by 1.
- Byte values:
  - ID: `grant` zero-extended to DBITS.
  - DATA: `payload`.
  - SUM: `SYNC_BYTE` ^ ID ^ `payload`, bitwise XOR, DBITS wide.
- `write_data` is 0 in IDLE.
- Requests that arrive mid-frame wait until the next IDLE. Arbitration happens only in IDLE.
- A `req` dropped before `ack` is legal and is simply not granted. Arbitration uses `req` as sampled in the IDLE cycle.
- Simultaneous `tx_full` rising and an emit cycle: no write; the byte is held.

## Timing
- Reset values:
  - state IDLE
  - `last_grant` = NREQ-1, so channel 0 wins first
  - `grant` 0, `payload` 0
  - `ack` 0, `write_uart` 0, `write_data` 0, `busy` 0, `frame_cnt` 0
- Reset mid-frame:
  - The frame is abandoned; the remaining bytes are never sent.
  - `write_uart`=0 from the cycle after the reset edge.
  - A pending `ack` pulse is cleared.
- Without backpressure, a frame takes 5 cycles:
  - 1 IDLE arbitration cycle.
  - 4 cycles with `write_uart`=1.
  - Back-to-back frames therefore issue 4 writes out of every 5 cycles.
- Latency from `req` high (block in IDLE, `tx_full`=0) to the first write: 1 cycle.
- `tx_full` is sampled every emit cycle; each cycle it is high adds exactly one hold cycle.
- At most one FIFO write per cycle. Because the write decision uses the current `tx_full`, a FIFO that updates full on the write edge is never overrun.
- `busy` rises one cycle after a grant and falls on the edge leaving SUM.

## Test plan
- Single request, `tx_full`=0: `req[2]`=1, data 0x3C -> writes 0xA5, 0x02, 0x3C, 0x9B on 4 consecutive cycles; `ack`=4'b0100 for 1 cycle; `frame_cnt`=1; `busy` low afterwards.
- Four requests at once after reset, payloads 0x10..0x13, each `req` dropped on its `ack` -> frames for channels 0, 1, 2, 3 in order; 20 cycles total; each `ack` bit pulses once; `frame_cnt`=4.
- Fairness: `req[0]` and `req[3]` held high continuously for 6 frames -> grant order 0, 3, 0, 3, 0, 3; channels 1 and 2 never acked.
- Backpressure: `tx_full`=1 for 10 cycles starting in DATA (channel 2, payload 0x3C) -> `write_uart`=0 and `write_data`=0x3C held for all 10 cycles; then 0x3C and 0x9B are written. No byte dropped or duplicated; a FIFO model receives exactly 4 bytes.
- Reset mid-frame right after SYNC is written -> `write_uart`=0 and `frame_cnt`=0 the next cycle. A new `req[1]` yields a complete frame 0xA5, 0x01, payload, checksum, with channel 0 priority restored.
- Counter wrap: 65536 back-to-back frames with `req[0]` held -> `frame_cnt` reads 0xFFFF then 0x0000 after the last SUM write.
